// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Imported by the memory stage and its data memory.
package mips_pkg;

  localparam int WORD          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  typedef struct packed {
    logic [1:0]            wbi;
    logic [REG_ADDR_W-1:0] regaddr;
    logic [WORD-1:0]       mem_data;
    logic [WORD-1:0]       alu_out;
  } mem_wb_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: one write port, one async read port.
// MEM_DEBUG_PORT_EN adds a second async read port for the debug unit.
module data_memory
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD-1:0]   wdata_i,
`ifdef MEM_DEBUG_PORT_EN
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [WORD-1:0]   dbg_data_o,
`endif
  output logic [WORD-1:0]   rdata_o
);

  logic [WORD-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

`ifdef MEM_DEBUG_PORT_EN
  assign dbg_data_o = mem_q[dbg_addr_i];
`endif

endmodule

// File: rtl/stage_mem.sv
// MIPS memory stage: data RAM access, branch redirect, MEM/WB register.
// Define MEM_DEBUG_PORT_EN to expose a debug read port on the RAM.
module stage_mem
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD-1:0]       alu_out,
  input  logic [WORD-1:0]       data_b,
  input  logic                  M,
  input  logic [1:0]            wbi,
  input  logic [REG_ADDR_W-1:0] regaddr,
  input  logic                  is_jump,
  input  logic                  branch_eq,
  input  logic                  branch_inc,
  input  logic                  zero,
  input  logic [WORD-1:0]       jump_address,
`ifdef MEM_DEBUG_PORT_EN
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [WORD-1:0]       dbg_data,
`endif
  output logic                  pc_src,
  output logic [WORD-1:0]       pc_target,
  output logic [1:0]            wbi_o,
  output logic [REG_ADDR_W-1:0] regaddr_o,
  output logic [WORD-1:0]       mem_data_o,
  output logic [WORD-1:0]       alu_out_o,
  output logic [WORD-1:0]       result_from_mem,
  output logic                  align_err
);

  mem_wb_t         wb_q, wb_d;
  logic            err_q, err_d;
  logic [ADDR_W-1:0] idx;
  logic [WORD-1:0] rd;
  logic            is_load, misal, we;
  logic            unused_addr;

  assign pc_src = is_jump
                | (branch_eq & zero)
                | (branch_inc & ~zero);
  assign pc_target = jump_address;

  // Upper address bits are dropped: accesses wrap modulo DEPTH words.
  assign idx         = alu_out[ADDR_W+1:2];
  assign unused_addr = ^alu_out[WORD-1:ADDR_W+2];

  assign is_load = wbi[WB_MEM_TO_REG];
  assign misal   = (alu_out[1:0] != 2'b00) & (M | is_load);
  // Gating with reset drops a store that lands on an edge inside reset.
  assign we      = M & ~misal & reset;

  data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dmem (
    .clk_i      (clock),
    .we_i       (we),
    .addr_i     (idx),
    .wdata_i    (data_b),
`ifdef MEM_DEBUG_PORT_EN
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
`endif
    .rdata_o    (rd)
  );

  always_comb begin
    wb_d          = '0;
    wb_d.wbi      = wbi;
    wb_d.regaddr  = regaddr;
    wb_d.alu_out  = alu_out;
    wb_d.mem_data = (is_load & ~misal) ? rd : '0;
    err_d         = err_q | misal;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      err_q <= err_d;
    end
  end

  assign wbi_o      = wb_q.wbi;
  assign regaddr_o  = wb_q.regaddr;
  assign mem_data_o = wb_q.mem_data;
  assign alu_out_o  = wb_q.alu_out;
  assign align_err  = err_q;

  assign result_from_mem = wbi_o[WB_MEM_TO_REG] ? mem_data_o : alu_out_o;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: loads/stores, branches, wrap,
// misalignment and asynchronous reset.
module tb_stage_mem;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_out, data_b, jump_address;
  logic        M, is_jump, branch_eq, branch_inc, zero;
  logic [1:0]  wbi;
  logic [4:0]  regaddr;
  logic        pc_src, align_err;
  logic [31:0] pc_target, mem_data_o, alu_out_o, result_from_mem;
  logic [1:0]  wbi_o;
  logic [4:0]  regaddr_o;
`ifdef MEM_DEBUG_PORT_EN
  logic [7:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  stage_mem dut (
    .clock           (clock),
    .reset           (reset),
    .alu_out         (alu_out),
    .data_b          (data_b),
    .M               (M),
    .wbi             (wbi),
    .regaddr         (regaddr),
    .is_jump         (is_jump),
    .branch_eq       (branch_eq),
    .branch_inc      (branch_inc),
    .zero            (zero),
    .jump_address    (jump_address),
`ifdef MEM_DEBUG_PORT_EN
    .dbg_addr        (dbg_addr),
    .dbg_data        (dbg_data),
`endif
    .pc_src          (pc_src),
    .pc_target       (pc_target),
    .wbi_o           (wbi_o),
    .regaddr_o       (regaddr_o),
    .mem_data_o      (mem_data_o),
    .alu_out_o       (alu_out_o),
    .result_from_mem (result_from_mem),
    .align_err       (align_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic m, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r);
    M = m; wbi = w; alu_out = a; data_b = d; regaddr = r;
  endtask

  task automatic br(input logic j, input logic eq,
                    input logic ne, input logic z);
    is_jump = j; branch_eq = eq; branch_inc = ne; zero = z;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    is_jump = 0; branch_eq = 0; branch_inc = 0; zero = 0;
    jump_address = 32'h0;
    step(); step();
    check("rst_wbi",   {30'd0, wbi_o}, 32'd0);
    check("rst_rd",    {27'd0, regaddr_o}, 32'd0);
    check("rst_mdata", mem_data_o, 32'd0);
    check("rst_alu",   alu_out_o, 32'd0);
    check("rst_err",   {31'd0, align_err}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // store then load same word
    step();
    drive(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0);
    step();
    drive(1'b0, 2'b11, 32'h10, 32'h0, 5'd4);
    step();
    check("ld_data", mem_data_o, 32'hDEADBEEF);
    check("ld_rfm",  result_from_mem, 32'hDEADBEEF);
    check("ld_wbi",  {30'd0, wbi_o}, 32'd3);
    check("ld_rd",   {27'd0, regaddr_o}, 32'd4);
    check("ld_err",  {31'd0, align_err}, 32'd0);

    // illegal M+load: captures pre-write value
    drive(1'b1, 2'b00, 32'h14, 32'h2222, 5'd0);
    step();
    drive(1'b1, 2'b01, 32'h14, 32'h3333, 5'd0);
    step();
    check("ml_pre", mem_data_o, 32'h2222);
    drive(1'b0, 2'b01, 32'h14, 32'h0, 5'd0);
    step();
    check("ml_post", mem_data_o, 32'h3333);

    // branch / jump redirect
    jump_address = 32'h40;
    br(0, 1, 0, 1);
    check("beq_t",  {31'd0, pc_src}, 32'd1);
    check("target", pc_target, 32'h40);
    br(0, 1, 0, 0);
    check("beq_nt", {31'd0, pc_src}, 32'd0);
    br(0, 0, 1, 0);
    check("bne_t",  {31'd0, pc_src}, 32'd1);
    br(0, 0, 1, 1);
    check("bne_nt", {31'd0, pc_src}, 32'd0);
    br(1, 0, 0, 0);
    check("jump",   {31'd0, pc_src}, 32'd1);
    br(0, 0, 0, 1);
    check("none",   {31'd0, pc_src}, 32'd0);

    // ALU pass-through
    drive(1'b0, 2'b10, 32'd7, 32'h0, 5'd3);
    step();
    check("pt_alu", alu_out_o, 32'd7);
    check("pt_rd",  {27'd0, regaddr_o}, 32'd3);
    check("pt_rfm", result_from_mem, 32'd7);
    check("pt_md",  mem_data_o, 32'd0);

    // address wrap modulo 1 KiB
    drive(1'b1, 2'b00, 32'h400, 32'hA5A5, 5'd0);
    step();
    drive(1'b0, 2'b11, 32'h0, 32'h0, 5'd1);
    step();
    check("wrap_lo", result_from_mem, 32'hA5A5);
    drive(1'b1, 2'b00, 32'h3FC, 32'hFF, 5'd0);
    step();
    drive(1'b0, 2'b11, 32'h7FC, 32'h0, 5'd1);
    step();
    check("wrap_hi", mem_data_o, 32'hFF);

    // misaligned store suppressed, error sticky
    drive(1'b1, 2'b00, 32'h13, 32'h1234, 5'd0);
    step();
    check("mis_err", {31'd0, align_err}, 32'd1);
    drive(1'b0, 2'b11, 32'h10, 32'h0, 5'd2);
    step();
    check("mis_mem", mem_data_o, 32'hDEADBEEF);
    check("mis_hold", {31'd0, align_err}, 32'd1);
    drive(1'b0, 2'b11, 32'h11, 32'h0, 5'd2);
    step();
    check("mis_ld", mem_data_o, 32'd0);
    check("mis_rfm", result_from_mem, 32'd0);
    drive(1'b0, 2'b10, 32'h8, 32'h0, 5'd2);
    step();
    check("mis_hold2", {31'd0, align_err}, 32'd1);

    // async reset mid-stream, in-flight store dropped
    drive(1'b0, 2'b11, 32'h10, 32'h0, 5'd9);
    step();
    check("pre_wbi", {30'd0, wbi_o}, 32'd3);
    drive(1'b1, 2'b11, 32'h10, 32'hBAD0, 5'd9);
    #1 reset = 1'b0;
    #1;
    check("ar_wbi",  {30'd0, wbi_o}, 32'd0);
    check("ar_rd",   {27'd0, regaddr_o}, 32'd0);
    check("ar_md",   mem_data_o, 32'd0);
    check("ar_alu",  alu_out_o, 32'd0);
    check("ar_err",  {31'd0, align_err}, 32'd0);
    step();
    check("ar_hold", {30'd0, wbi_o}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 2'b11, 32'h10, 32'h0, 5'd1);
    step();
    check("ar_drop", mem_data_o, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
